// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : loader_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader (FSM state encoding, bytes per packed word).
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is willing to take a stream byte
    function automatic logic accepts_bytes(input loader_state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : imem_boot_loader_if
// Description : Byte-stream valid/ready channel plus instruction-memory write
//               port. master = host/memory side, slave = loader side.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Little-endian 8-to-32 packer. The first byte of a word lands
//               in bits [7:0]; o_word_valid pulses combinationally alongside
//               the fourth byte so the caller can register the write.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    localparam logic [1:0] c_last_lane = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  r_lane;
    logic [23:0] r_acc;

    // The top byte is never stored: it is forwarded straight into the word
    assign o_word_valid = i_byte_en && (r_lane == c_last_lane);
    assign o_word       = {i_byte, r_acc};

    // Byte lane counter (wraps 3->0) and lower-three-byte accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane <= 2'd0;
            r_acc  <= 24'd0;
        end else if (i_clr) begin
            r_lane <= 2'd0;
            r_acc  <= 24'd0;
        end else if (i_byte_en) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
                2'd0:    r_acc[7:0]   <= i_byte;
                2'd1:    r_acc[15:8]  <= i_byte;
                2'd2:    r_acc[23:16] <= i_byte;
                default: r_acc        <= r_acc;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Receives a length-prefixed little-endian byte stream, packs it
//               into 32-bit words, writes them to instruction memory and holds
//               the core in reset until the image is complete.
// Config      : LOADER_CHECKSUM_EN - adds a trailing XOR checksum byte (CHK).
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus,
    input  logic              load_req,
    output logic              core_rst,
    output logic              done,
    output logic              error
);
    localparam logic [15:0] c_depth = 16'(IMEM_DEPTH);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic              r_in_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_word_idx;
    logic [7:0]        r_n_lo;
    logic [15:0]       r_n;
    logic              w_xfer;
    logic              w_restart;
    logic [15:0]       w_n_hdr;
    logic              w_last_word;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_in_ready_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;

    assign w_xfer      = bus.in_valid & r_in_ready;
    assign w_restart   = load_req & ((r_state == DONE) | (r_state == ERR));
    assign w_n_hdr     = {bus.in_data, r_n_lo};
    assign w_last_word = w_word_valid && (16'(r_word_idx) == r_n - 16'd1);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t c_after_data = CHK;
    logic [7:0] r_csum;

    // Running XOR over every header and data byte accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= 8'd0;
        end else if (w_restart) begin
            r_csum <= 8'd0;
        end else if (w_xfer && (r_state != CHK)) begin
            r_csum <= r_csum ^ bus.in_data;
        end
    end
`else
    localparam loader_state_t c_after_data = DONE;
`endif

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_restart),
        .i_byte_en    (w_xfer && (r_state == DATA)),
        .i_byte       (bus.in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= HDR_LO;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HDR_LO: if (w_xfer) w_state_nxt = HDR_HI;
            HDR_HI: begin
                if (w_xfer) begin
                    if (w_n_hdr > c_depth)     w_state_nxt = ERR;
                    else if (w_n_hdr == 16'd0) w_state_nxt = c_after_data;
                    else                       w_state_nxt = DATA;
                end
            end
            DATA:   if (w_last_word) w_state_nxt = c_after_data;
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_xfer) w_state_nxt = (bus.in_data == r_csum) ? DONE : ERR;
`else
                w_state_nxt = ERR;
`endif
            end
            DONE, ERR: if (w_restart) w_state_nxt = HDR_LO;
            default:   w_state_nxt = ERR;
        endcase
    end

    // Output decode; done waits one extra cycle when leaving DATA so it
    // follows the final imem write rather than coinciding with it
    always_comb begin
        w_in_ready_nxt = accepts_bytes(w_state_nxt);
        w_done_nxt     = (w_state_nxt == DONE) && (r_state != DATA);
        w_error_nxt    = (w_state_nxt == ERR);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_imem_we  <= w_word_valid;
            r_core_rst <= !w_done_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            if (w_word_valid) begin
                r_imem_addr  <= r_word_idx;
                r_imem_wdata <= w_word;
            end
        end
    end

    // Header capture and word index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n_lo     <= 8'd0;
            r_n        <= 16'd0;
            r_word_idx <= '0;
        end else if (w_restart) begin
            r_word_idx <= '0;
        end else begin
            if (w_xfer && (r_state == HDR_LO)) r_n_lo <= bus.in_data;
            if (w_xfer && (r_state == HDR_HI)) r_n    <= w_n_hdr;
            if (w_word_valid)                  r_word_idx <= r_word_idx + 1'b1;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    // A restart request raises core reset in the very cycle it is seen
    assign core_rst       = r_core_rst | w_restart;
    assign done           = r_done;
    assign error          = r_error;
endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader: vector table,
//               randomized images against a reference model, and hand-written
//               restart / reset corner cases. LOADER_CHECKSUM_EN aware.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic load_req = 1'b0;
    logic core_rst;
    logic done;
    logic error;

    imem_boot_loader_if #(.ADDR_W(AW)) bus ();

    imem_boot_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .load_req (load_req),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // ---------------- monitor: records writes and done rise ----------------
    int          cyc_cnt       = 0;
    int          wr_cnt        = 0;
    int          last_wr_cyc   = 0;
    int          done_rise_cyc = 0;
    logic        done_q        = 1'b0;
    int          wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        done_q  <= done;
        if (done && !done_q) done_rise_cyc <= cyc_cnt;
        if (bus.imem_we) begin
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] <= int'(bus.imem_addr);
                wr_data[wr_cnt] <= bus.imem_wdata;
            end
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc_cnt;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   64'(bus.in_ready),   64'd0);
        check({tag, "_imem_we"},    64'(bus.imem_we),    64'd0);
        check({tag, "_imem_addr"},  64'(bus.imem_addr),  64'd0);
        check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, "_core_rst"},   64'(core_rst),       64'd1);
        check({tag, "_done"},       64'(done),           64'd0);
        check({tag, "_error"},      64'(error),          64'd0);
    endtask

    // ---------------- stimulus and reference model ----------------
    logic [7:0]  stim[$];
    logic [31:0] exp_words[$];
    logic        exp_done;
    logic        exp_err;

    task automatic build_stim(input int n);
        stim.delete();
        stim.push_back(n[7:0]);
        stim.push_back(n[15:8]);
        if (n <= DEPTH) begin
            for (int k = 0; k < 4 * n; k++) stim.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            append_csum();
`endif
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic append_csum();
        logic [7:0] x;
        x = 8'd0;
        foreach (stim[k]) x ^= stim[k];
        stim.push_back(x);
    endtask
`endif

    // Image semantics: 16-bit LE word count, then LE words, optional XOR byte
    task automatic model_stim();
        int n;
        exp_words.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'({stim[1], stim[0]});
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_words.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int k = 0; k < 2 + 4 * n; k++) x ^= stim[k];
            if (stim[2+4*n] == x) exp_done = 1'b1;
            else                  exp_err  = 1'b1;
        end
`else
        exp_done = 1'b1;
`endif
    endtask

    // gap_mode: 0 none, 1 every other cycle, 2 random; noise pulses load_req mid-load
    task automatic send_stim(input string tag, input int gap_mode, input bit noise);
        int idx = 0;
        int cyc = 0;
        int limit = 8 * stim.size() + 40;
        while (idx < stim.size() && cyc < limit) begin
            @(negedge clk);
            load_req = noise && (cyc == 5);
            if ((gap_mode == 1 && (cyc % 2) == 1) ||
                (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = stim[idx];
            end
            if (bus.in_valid && bus.in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        load_req     = 1'b0;
        check({tag, "_bytes_taken"}, 64'(idx), 64'(stim.size()));
    endtask

    task automatic run_stream(input string tag, input int gap_mode, input bit noise);
        int base;
        int t = 0;
        int nw;
        #1;
        base = wr_cnt;
        send_stim(tag, gap_mode, noise);
        while (!(done || error) && t < 400) begin
            @(negedge clk);
            t++;
        end
        #1;
        check({tag, "_finished"}, 64'(done | error), 64'd1);
        nw = wr_cnt - base;
        check({tag, "_nwrites"}, 64'(nw), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < nw; i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_addr[base+i]), 64'(i));
            check($sformatf("%s_wr%0d_data", tag, i), 64'(wr_data[base+i]), 64'(exp_words[i]));
        end
`ifndef LOADER_CHECKSUM_EN
        if (exp_done && nw > 0)
            check({tag, "_done_after_last_we"}, 64'(done_rise_cyc), 64'(last_wr_cyc + 1));
`endif
        check({tag, "_done"},     64'(done),         64'(exp_done));
        check({tag, "_error"},    64'(error),        64'(exp_err));
        check({tag, "_core_rst"}, 64'(core_rst),     64'(!exp_done));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        // A byte presented while not ready must not be consumed
        base = wr_cnt;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check({tag, "_hold_no_write"}, 64'(wr_cnt - base), 64'd0);
        check({tag, "_hold_status"},   64'({done, error}), 64'({exp_done, exp_err}));
    endtask

    task automatic restart(input string tag);
        @(negedge clk);
        load_req = 1'b1;
        #1;
        check({tag, "_rst_same_cycle"}, 64'(core_rst), 64'd1);
        @(negedge clk);
        load_req = 1'b0;
        #1;
        check({tag, "_rst_done"},     64'(done),         64'd0);
        check({tag, "_rst_error"},    64'(error),        64'd0);
        check({tag, "_rst_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_rst_core_rst"}, 64'(core_rst),     64'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [79:0] bytes;
        logic [3:0]  len;
        logic [1:0]  gap;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl [0:4];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        tbl[0] = '{bytes: 80'h0281_2623_fe01_0113_0002, len: 4'd10, gap: 2'd0,
                   exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd2, w0: 32'hfe010113, w1: 32'h02812623};
        tbl[1] = '{bytes: 80'h0281_2623_fe01_0113_0002, len: 4'd10, gap: 2'd1,
                   exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd2, w0: 32'hfe010113, w1: 32'h02812623};
        tbl[2] = '{bytes: 80'h0, len: 4'd2, gap: 2'd0,
                   exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd0, w0: 32'h0, w1: 32'h0};
        tbl[3] = '{bytes: 80'h41, len: 4'd2, gap: 2'd0,
                   exp_done: 1'b0, exp_err: 1'b1, exp_nw: 2'd0, w0: 32'h0, w1: 32'h0};
        tbl[4] = '{bytes: 80'h6f_0001, len: 4'd6, gap: 2'd2,
                   exp_done: 1'b1, exp_err: 1'b0, exp_nw: 2'd1, w0: 32'h0000006f, w1: 32'h0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("por_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("por_release_core_rst", 64'(core_rst),     64'd1);
        check("por_release_done",     64'(done),         64'd0);

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            stim.delete();
            for (int k = 0; k < int'(tbl[i].len); k++) stim.push_back(tbl[i].bytes[8*k +: 8]);
`ifdef LOADER_CHECKSUM_EN
            if (int'({stim[1], stim[0]}) <= DEPTH) append_csum();
`endif
            exp_words.delete();
            if (tbl[i].exp_nw >= 2'd1) exp_words.push_back(tbl[i].w0);
            if (tbl[i].exp_nw >= 2'd2) exp_words.push_back(tbl[i].w1);
            exp_done = tbl[i].exp_done;
            exp_err  = tbl[i].exp_err;
            run_stream($sformatf("vec%0d", i), int'(tbl[i].gap), 1'b0);
            restart($sformatf("vec%0d", i));
        end

`ifdef LOADER_CHECKSUM_EN
        // Checksum good / bad
        stim = '{8'h01, 8'h00, 8'h93, 8'h07, 8'h50, 8'h00, 8'hC5};
        exp_words = '{32'h00500793};
        exp_done = 1'b1;
        exp_err  = 1'b0;
        run_stream("csum_ok", 0, 1'b0);
        restart("csum_ok");
        stim = '{8'h01, 8'h00, 8'h93, 8'h07, 8'h50, 8'h00, 8'hC4};
        exp_done = 1'b0;
        exp_err  = 1'b1;
        run_stream("csum_bad", 0, 1'b0);
        restart("csum_bad");
`endif

        // Full-depth image
        build_stim(DEPTH);
        model_stim();
        run_stream("full", 2, 1'b0);
        check("full_last_addr", 64'(wr_addr[wr_cnt-1]), 64'(DEPTH - 1));
        restart("full");

        // Randomized images with gaps and ignored load_req pulses
        for (int it = 0; it < 12; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      n = int'($urandom_range(DEPTH + 1, 300));
            else if (r == 1) n = 0;
            else             n = int'($urandom_range(1, 6));
            build_stim(n);
            model_stim();
            run_stream($sformatf("rnd%0d", it), int'($urandom_range(0, 2)), 1'($urandom));
            restart($sformatf("rnd%0d", it));
        end

        // Reset asserted after five data bytes of a two-word image
        stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_stim("midrst", 0, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_release_in_ready", 64'(bus.in_ready), 64'd1);
        stim = '{8'h01, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        append_csum();
`endif
        exp_words = '{32'h0000006f};
        exp_done  = 1'b1;
        exp_err   = 1'b0;
        run_stream("midrst_reload", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
